// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// Combinational lookup; on a miss the whole line is refilled word by word,
// in ascending order from the line base, over a req/ack memory interface.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = CNT_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 - OFF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              flush_pend;
  logic [NUM_LINES-1:0] valid;
  logic [LINE_W-1:0] refill_base;   // line address of the refill in flight

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [31:0]       data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [CNT_W-1:0]  pc_word;
  logic [TAG_W-1:0]  rf_tag;
  logic [IDX_W-1:0]  rf_idx;
  logic              unused_pc_bits;

  assign pc_tag  = pc[31:OFF_W+IDX_W];
  assign pc_idx  = pc[OFF_W+IDX_W-1:OFF_W];
  assign pc_word = pc[OFF_W-1:2];
  assign unused_pc_bits = ^pc[1:0];

  assign rf_tag = refill_base[LINE_W-1:IDX_W];
  assign rf_idx = refill_base[IDX_W-1:0];

  // Lookup is only trusted in IDLE; a miss returns a nop word.
  assign hit      = (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign instr    = hit ? data_mem[{pc_idx, pc_word}] : 32'h0;
  assign stall    = ~hit;
  assign mem_req  = (state == REFILL);
  assign mem_addr = {refill_base, cnt, 2'b00};

  // Control FSM: miss detection, refill word counting, valid bits and flush handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          if (!hit) begin
            cnt   <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              // A flush seen at any point of the refill leaves the new line invalid too.
              state      <= IDLE;
              flush_pend <= 1'b0;
              if (flush_pend || flush) valid <= '0;
              else                     valid[rf_idx] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Storage: capture the line base on a miss, then fill data words and the tag
  always_ff @(posedge clk) begin
    if (state == IDLE && !hit) refill_base <= pc[31:OFF_W];
    if (state == REFILL && mem_ack) begin
      data_mem[{rf_idx, cnt}] <= mem_rdata;
      if (cnt == LAST) tag_mem[rf_idx] <= rf_tag;
    end
  end

endmodule
